// File: rtl/xlink_msg_proc_pkg.sv
// Shared definitions for the XLink message processor: token encodings,
// FSM state encoding, payload operation codes and the payload byte operation.
package xlink_msg_proc_pkg;

    // Token format: bit 8 set marks a control token, [7:0] carries the value.
    localparam int         CTRL_BIT   = 8;
    localparam logic [8:0] EOM_TOKEN  = 9'h101;
    localparam logic [8:0] NULL_TOKEN = 9'h000;
    localparam logic [7:0] XOR_KEY    = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_STORE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_SEND  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ECHO = 2'd0,
        OP_INC  = 2'd1,
        OP_INV  = 2'd2,
        OP_XOR  = 2'd3
    } op_t;

    // Per-message payload transform; 8-bit arithmetic wraps naturally.
    function automatic logic [7:0] byte_op(input op_t op, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            OP_ECHO: r = b;
            OP_INC:  r = b + 8'd1;
            OP_INV:  r = ~b;
            OP_XOR:  r = b ^ XOR_KEY;
            default: r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/xlink_msg_buf.sv
// Single-message token store: synchronous write, asynchronous read.
// The payload operation is applied on the read path so the stored tokens
// stay exactly as received.
module xlink_msg_buf
    import xlink_msg_proc_pkg::*;
#(
    parameter int DEPTH = 19,
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [8:0]       wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    input  logic             rd_op_en,
    input  op_t              rd_op,
    output logic [8:0]       rd_data
);

    localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH - 1);

    logic [8:0] mem [DEPTH];
    logic [8:0] raw;

    // Store one received token per write strobe.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST_ADDR)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read with out-of-range guard; payload entries leave as data tokens.
    always_comb begin
        raw     = (rd_addr <= LAST_ADDR) ? mem[rd_addr] : NULL_TOKEN;
        rd_data = rd_op_en ? {1'b0, byte_op(rd_op, raw[7:0])} : raw;
    end

endmodule

// File: rtl/xlink_msg_proc.sv
// XLink message processor: buffers one inbound message from the rx token
// buffer and returns it to the originator with a rewritten header and a
// transformed payload.
//
// state | meaning
// IDLE  | waiting for the first token of a message; op_mode latched here
// READ  | issue one rx read strobe when a token is available
// STORE | rx token valid: store data, ignore control, act on EOM
// DRAIN | message too long: discard tokens up to and including EOM
// SEND  | present reply tokens to the tx arbiter until EOM is taken
module xlink_msg_proc
    import xlink_msg_proc_pkg::*;
#(
    parameter int         HDR_LEN     = 3,
    parameter int         MAX_PAYLOAD = 16,
    parameter int         PTR_W       = 5,
    parameter logic [7:0] REPLY_CHAN  = 8'h02
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] rx_buf_dout,
    input  logic       rx_buf_empty,
    output logic       rx_buf_en,
    output logic [8:0] tx_token_out,
    output logic       tx_token_valid,
    input  logic       tx_token_taken,
    input  logic [1:0] op_mode,
    output logic       busy,
    output logic       msg_done,
    output logic       err_overflow,
    output logic       err_runt
);

    localparam int               DEPTH    = HDR_LEN + MAX_PAYLOAD;
    localparam logic [PTR_W-1:0] FULL_IDX = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] HDR_IDX  = PTR_W'(HDR_LEN);
    localparam logic [PTR_W-1:0] LAST_HDR = PTR_W'(HDR_LEN - 1);

    state_t           state, state_nxt;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] tx_idx;
    op_t              op_q;
    logic             drain_wait;
    logic             buf_wr_en;
    logic [8:0]       buf_rd;

    logic is_eom, is_ctrl, is_full, tx_xfer, tx_last;

    assign is_eom  = (rx_buf_dout == EOM_TOKEN);
    assign is_ctrl = rx_buf_dout[CTRL_BIT];
    assign is_full = (idx == FULL_IDX);
    assign tx_xfer = tx_token_valid && tx_token_taken;
    assign tx_last = (tx_idx == idx);

    xlink_msg_buf #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk      (clk),
        .wr_en    (buf_wr_en),
        .wr_addr  (idx),
        .wr_data  (rx_buf_dout),
        .rd_addr  (tx_idx),
        .rd_op_en (tx_idx >= HDR_IDX),
        .rd_op    (op_q),
        .rd_data  (buf_rd)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!rx_buf_empty) state_nxt = ST_READ;
            ST_READ:  if (!rx_buf_empty) state_nxt = ST_STORE;
            ST_STORE: begin
                if (is_eom)       state_nxt = (idx < HDR_IDX) ? ST_IDLE : ST_SEND;
                else if (is_ctrl) state_nxt = ST_READ;
                else if (is_full) state_nxt = ST_DRAIN;
                else              state_nxt = ST_READ;
            end
            ST_DRAIN: if (drain_wait && is_eom) state_nxt = ST_IDLE;
            ST_SEND:  if (tx_xfer && tx_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; reply header fields are rewritten here.
    always_comb begin
        rx_buf_en      = 1'b0;
        tx_token_valid = 1'b0;
        tx_token_out   = NULL_TOKEN;
        buf_wr_en      = 1'b0;
        busy           = (state != ST_IDLE);
        case (state)
            ST_READ:  rx_buf_en = !rx_buf_empty;
            ST_DRAIN: rx_buf_en = !drain_wait && !rx_buf_empty;
            ST_STORE: buf_wr_en = !is_ctrl && !is_full;
            ST_SEND: begin
                tx_token_valid = 1'b1;
                if (tx_last)                 tx_token_out = EOM_TOKEN;
                else if (tx_idx == '0)       tx_token_out = NULL_TOKEN;
                else if (tx_idx == LAST_HDR) tx_token_out = {1'b0, REPLY_CHAN};
                else                         tx_token_out = buf_rd;
            end
            default: ;
        endcase
    end

    // Index counters, op latch, drain handshake and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            tx_idx       <= '0;
            op_q         <= OP_ECHO;
            drain_wait   <= 1'b0;
            msg_done     <= 1'b0;
            err_overflow <= 1'b0;
            err_runt     <= 1'b0;
        end else begin
            msg_done     <= 1'b0;
            err_overflow <= 1'b0;
            err_runt     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_buf_empty) begin
                        op_q   <= op_t'(op_mode);
                        idx    <= '0;
                        tx_idx <= '0;
                    end
                end
                ST_STORE: begin
                    drain_wait <= 1'b0;
                    tx_idx     <= '0;
                    if (!is_ctrl && !is_full) idx <= idx + PTR_W'(1);
                    if (is_eom && (idx < HDR_IDX)) err_runt <= 1'b1;
                end
                ST_DRAIN: begin
                    if (drain_wait) begin
                        drain_wait <= 1'b0;
                        if (is_eom) err_overflow <= 1'b1;
                    end else begin
                        drain_wait <= !rx_buf_empty;
                    end
                end
                ST_SEND: begin
                    if (tx_xfer) begin
                        if (tx_last) msg_done <= 1'b1;
                        else         tx_idx <= tx_idx + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xlink_msg_proc.sv
// Randomized scoreboard bench for xlink_msg_proc: a reference model turns each
// inbound message into expected reply tokens and status events; a monitor
// checks them against what the DUT presents.
module tb_xlink_msg_proc;

    localparam int         HDR  = 3;
    localparam int         MAXP = 16;
    localparam logic [8:0] EOM  = 9'h101;
    localparam logic [8:0] NOISE = 9'h1C3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] rx_buf_dout = '0;
    logic       rx_buf_empty = 1'b1;
    logic       rx_buf_en;
    logic [8:0] tx_token_out;
    logic       tx_token_valid;
    logic       tx_token_taken = 1'b0;
    logic [1:0] op_mode = 2'd0;
    logic       busy, msg_done, err_overflow, err_runt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int taken_mode = 0;   // 0 tied high, 1 random, 2 driven by the main sequence

    logic [9:0] exp_tx[$];   // {first-of-message, token}
    int         exp_evt[$];  // 0 msg_done, 1 err_overflow, 2 err_runt
    logic [8:0] rx_q[$];
    logic [8:0] msg_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xlink_msg_proc dut (
        .clk            (clk),
        .reset          (reset),
        .rx_buf_dout    (rx_buf_dout),
        .rx_buf_empty   (rx_buf_empty),
        .rx_buf_en      (rx_buf_en),
        .tx_token_out   (tx_token_out),
        .tx_token_valid (tx_token_valid),
        .tx_token_taken (tx_token_taken),
        .op_mode        (op_mode),
        .busy           (busy),
        .msg_done       (msg_done),
        .err_overflow   (err_overflow),
        .err_runt       (err_runt)
    );

    // rx buffer model: data appears one cycle after the read strobe
    initial begin : rx_drv
        logic en_s;
        forever begin
            @(negedge clk);
            en_s = rx_buf_en;
            @(posedge clk);
            #1;
            if (en_s && rx_q.size() > 0) rx_buf_dout = rx_q.pop_front();
            rx_buf_empty = (rx_q.size() == 0);
        end
    end

    // tx consumer
    initial begin : taken_drv
        forever begin
            @(posedge clk);
            #1;
            if (taken_mode == 0)      tx_token_taken = 1'b1;
            else if (taken_mode == 1) tx_token_taken = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_evt(input logic pulse, input int code);
        int e;
        if (pulse) begin
            checks++;
            if (exp_evt.size() == 0) begin
                failures++;
                $display("FAIL event: unexpected pulse code %0d at cycle %0d", code, cyc);
            end else begin
                e = exp_evt.pop_front();
                if (e != code) begin
                    failures++;
                    $display("FAIL event: got code %0d expected code %0d", code, e);
                end
            end
        end
    endtask

    // monitor: scoreboard pops on every transfer and every status pulse
    initial begin : monitor
        logic       prev_stall;
        logic [8:0] prev_tok;
        int         last_cyc;
        logic [9:0] e;
        prev_stall = 1'b0;
        prev_tok   = '0;
        last_cyc   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!tx_token_valid || tx_token_out !== prev_tok) begin
                        failures++;
                        $display("FAIL stall_hold: valid=%0b tok=%h required valid=1 tok=%h",
                                 tx_token_valid, tx_token_out, prev_tok);
                    end
                end
                if (rx_buf_empty) chk("rx_en_while_empty", {8'h0, rx_buf_en}, 9'h0);
                if (tx_token_valid && tx_token_taken) begin
                    checks++;
                    if (exp_tx.size() == 0) begin
                        failures++;
                        $display("FAIL tx_token: got %h expected none", tx_token_out);
                    end else begin
                        e = exp_tx.pop_front();
                        if (tx_token_out !== e[8:0]) begin
                            failures++;
                            $display("FAIL tx_token: got %h expected %h", tx_token_out, e[8:0]);
                        end
                        if (!e[9] && taken_mode == 0) begin
                            checks++;
                            if (cyc != last_cyc + 1) begin
                                failures++;
                                $display("FAIL back_to_back: gap %0d cycles expected 1", cyc - last_cyc);
                            end
                        end
                    end
                    last_cyc = cyc;
                end else if (tx_token_valid && exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_valid: got valid=1 expected no reply token pending");
                end
                check_evt(msg_done, 0);
                check_evt(err_overflow, 1);
                check_evt(err_runt, 2);
                prev_stall = tx_token_valid && !tx_token_taken;
                prev_tok   = tx_token_out;
            end
        end
    end

    function automatic logic [7:0] ref_op(input int mode, input logic [7:0] b);
        int v;
        v = int'(b);
        case (mode)
            1:       v = (v + 1) % 256;
            2:       v = 255 - v;
            3:       v = int'(b ^ 8'h5A);
            default: v = int'(b);
        endcase
        return 8'(v);
    endfunction

    // reference model: what reply (or error) the message in msg_q must produce
    task automatic push_model(input int mode);
        int         nd;
        bit         ovf;
        logic [7:0] d[$];
        logic [8:0] t;
        nd  = 0;
        ovf = 0;
        for (int i = 0; i < msg_q.size(); i++) begin
            t = msg_q[i];
            if (t == EOM) break;
            if (!t[8]) begin
                nd++;
                if (nd > HDR + MAXP) ovf = 1;
                else d.push_back(t[7:0]);
            end
        end
        if (ovf) exp_evt.push_back(1);
        else if (nd < HDR) exp_evt.push_back(2);
        else begin
            exp_tx.push_back({1'b1, 9'h000});
            for (int i = 1; i < HDR - 1; i++) exp_tx.push_back({2'b00, d[i]});
            exp_tx.push_back({2'b00, 8'h02});
            for (int i = HDR; i < d.size(); i++) exp_tx.push_back({2'b00, ref_op(mode, d[i])});
            exp_tx.push_back({1'b0, EOM});
            exp_evt.push_back(0);
        end
    endtask

    task automatic mk(input int n_hdr, input int n_pay, input int fixed, input bit noise);
        msg_q.delete();
        for (int i = 0; i < n_hdr; i++) msg_q.push_back({1'b0, 8'($urandom_range(0, 255))});
        for (int i = 0; i < n_pay; i++)
            msg_q.push_back({1'b0, (fixed >= 0) ? 8'(fixed) : 8'($urandom_range(0, 255))});
        if (noise) msg_q.insert($urandom_range(0, msg_q.size()), NOISE);
        msg_q.push_back(EOM);
    endtask

    // op_mode is scrambled once the message is under way; it must not matter
    task automatic issue(input int mode);
        op_mode = 2'(mode);
        push_model(mode);
        @(negedge clk);
        foreach (msg_q[i]) rx_q.push_back(msg_q[i]);
        repeat (4) @(posedge clk);
        op_mode = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_evt.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL timeout: %0d tokens and %0d events still pending", exp_tx.size(), exp_evt.size());
            exp_tx.delete();
            exp_evt.delete();
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("busy_after_msg", {8'h0, busy}, 9'h0);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_token_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL wait_valid: got valid=0 after %0d cycles expected valid=1", n);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rx_en"},   {8'h0, rx_buf_en},      9'h0);
        chk({tag, "_tx_tok"},  tx_token_out,           9'h0);
        chk({tag, "_tx_vld"},  {8'h0, tx_token_valid}, 9'h0);
        chk({tag, "_busy"},    {8'h0, busy},           9'h0);
        chk({tag, "_done"},    {8'h0, msg_done},       9'h0);
        chk({tag, "_ovf"},     {8'h0, err_overflow},   9'h0);
        chk({tag, "_runt"},    {8'h0, err_runt},       9'h0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int kind, mode;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // directed: basic reply, op +1, consumer always ready
        taken_mode = 0;
        msg_q = '{9'h001, 9'h003, 9'h005, 9'h041, EOM};
        issue(1);
        wait_done();

        // directed payload ops including wrap
        mk(HDR, 1, 8'hFF, 0); issue(1); wait_done();
        mk(HDR, 1, 8'h0F, 0); issue(2); wait_done();
        mk(HDR, 1, 8'h5A, 0); issue(3); wait_done();

        // directed: longest legal message, then one too long, then recovery
        mk(HDR, MAXP, -1, 0); issue(0); wait_done();
        mk(HDR, MAXP + 1, -1, 0); issue(1); wait_done();
        msg_q = '{9'h001, 9'h003, 9'h005, 9'h041, EOM};
        issue(1); wait_done();

        // directed: runt and empty payload
        msg_q = '{9'h001, EOM};
        issue(0); wait_done();
        msg_q = '{9'h001, 9'h003, 9'h005, EOM};
        issue(2); wait_done();

        // directed: consumer stalls 10 cycles on the second token
        taken_mode = 2;
        tx_token_taken = 1'b1;
        mk(HDR, 4, -1, 0);
        issue(3);
        wait_valid();
        @(posedge clk);
        #1 tx_token_taken = 1'b0;
        repeat (10) @(posedge clk);
        #1 tx_token_taken = 1'b1;
        wait_done();

        // random messages: lengths, runts, overflows, noise, consumer backpressure
        for (int it = 0; it < 30; it++) begin
            taken_mode = $urandom_range(0, 1);
            kind = $urandom_range(0, 9);
            mode = $urandom_range(0, 3);
            if (kind == 0)      mk($urandom_range(0, HDR - 1), 0, -1, 0);
            else if (kind == 1) mk(HDR, $urandom_range(MAXP + 1, MAXP + 4), -1, 1'($urandom_range(0, 1)));
            else                mk(HDR, $urandom_range(0, MAXP), -1, 1'($urandom_range(0, 1)));
            issue(mode);
            wait_done();
        end

        // reset in the middle of SEND
        taken_mode = 2;
        tx_token_taken = 1'b0;
        mk(HDR, 5, -1, 0);
        issue(1);
        wait_valid();
        @(posedge clk);
        #2 reset = 1'b1;
        rx_q.delete();
        exp_tx.delete();
        exp_evt.delete();
        rx_buf_empty = 1'b1;
        #1;
        check_all_zero("mid_send_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        taken_mode = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("post_reset_busy", {8'h0, busy}, 9'h0);
        chk("post_reset_valid", {8'h0, tx_token_valid}, 9'h0);
        chk("post_reset_rx_en", {8'h0, rx_buf_en}, 9'h0);

        // recovery after reset
        msg_q = '{9'h001, 9'h003, 9'h005, 9'h041, 9'h0FF, EOM};
        issue(1);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
